// File: rtl/shared_adder_arbiter_pkg.sv
// Shared definitions for the shared_adder_arbiter block: default sizes,
// grant-counter width and the result-register state encoding.
package shared_adder_arbiter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_REQ = 3;
  localparam int STAT_W    = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans the request vector starting at ptr_i, wrapping
// from N_REQ-1 back to 0, and grants the first active requester.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  // Priority scan from the pointer; the first hit wins and later hits are ignored.
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: N_REQ requesters share one registered adder.
// A round-robin arbiter picks at most one request per cycle; the result
// register drains and refills in the same cycle when the consumer is ready.
// Optional feature: define SHARED_ADDER_ARB_STATS_EN to add per-requester
// 16-bit saturating grant counters on port stat_grants.
module shared_adder_arbiter
  import shared_adder_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
`ifdef SHARED_ADDER_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0] stat_grants,
`endif
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_carry,
  output logic [IW-1:0]          res_id
);

  out_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IW-1:0]    id_q;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   add_full;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Accept when the result register is empty or is being drained this cycle;
  // nothing is accepted while reset is held.
  always_comb begin
    can_accept = (state_q == EMPTY) || res_ready;
    req_ready  = (can_accept && !reset) ? gnt : '0;
    xfer       = gnt_any && can_accept && !reset;
    a_sel      = req_a[gnt_idx*WIDTH +: WIDTH];
    b_sel      = req_b[gnt_idx*WIDTH +: WIDTH];
    add_full   = {1'b0, a_sel} + {1'b0, b_sel};
  end

  // Next-state for the result register and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (xfer) state_d = FULL;
               else if (res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (xfer) ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // State, pointer and result registers; an accepted request loads the sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        sum_q   <= add_full[WIDTH-1:0];
        carry_q <= add_full[WIDTH];
        id_q    <= gnt_idx;
      end
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign res_id    = id_q;

`ifdef SHARED_ADDER_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    // Count transfers for requester i, sticking at all-ones.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else if (xfer && gnt_idx == IW'(i) && cnt_q[i] != {STAT_W{1'b1}}) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
    assign stat_grants[i*STAT_W +: STAT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_shared_adder_arbiter.sv
module tb_shared_adder_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           res_valid, res_ready, res_carry;
  logic [W-1:0]   res_sum;
  logic [1:0]     res_id;
`ifdef SHARED_ADDER_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
`endif

  int total = 0;
  int bad   = 0;

  shared_adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
`ifdef SHARED_ADDER_ARB_STATS_EN
    .stat_grants (stat_grants),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 3'b111; res_ready = 1'b1;
    req_a = '0; req_b = '0;
    tick; tick;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready: got %b want 000", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    total++; if (res_sum !== 32'd0 || res_carry !== 1'b0 || res_id !== 2'd0) begin
      bad++; $display("FAIL rst_data: got sum=%0h c=%b id=%0d want 0 0 0", res_sum, res_carry, res_id); end
    req_valid = '0;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    req_valid = 3'b001; res_ready = 1'b1;
    req_a[0*W +: W] = 32'd10; req_b[0*W +: W] = 32'd20;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_ready: got %b want 001", req_ready); end
    tick;
    req_valid = '0;
    #1;
    total++; if (res_valid !== 1'b1 || res_sum !== 32'd30 || res_carry !== 1'b0 || res_id !== 2'd0) begin
      bad++; $display("FAIL single_res: got v=%b sum=%0d c=%b id=%0d want 1 30 0 0", res_valid, res_sum, res_carry, res_id); end
    tick;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", res_valid); end
  endtask

  task automatic test_overflow;
    // pointer is 1 here; only requester 2 asks
    req_valid = 3'b100;
    req_a[2*W +: W] = 32'hFFFF_FFFF; req_b[2*W +: W] = 32'h0000_0001;
    #1;
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL ovf_ready: got %b want 100", req_ready); end
    tick;
    req_valid = '0;
    #1;
    total++; if (res_sum !== 32'h0 || res_carry !== 1'b1 || res_id !== 2'd2) begin
      bad++; $display("FAIL ovf_res: got sum=%0h c=%b id=%0d want 0 1 2", res_sum, res_carry, res_id); end
    tick;
  endtask

  task automatic test_fairness;
    logic [N-1:0] exp_rdy [3];
    logic [W-1:0] exp_sum [3];
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
    exp_sum[0] = 32'd100; exp_sum[1] = 32'd201; exp_sum[2] = 32'd302;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(100 * (i + 1));
      req_b[i*W +: W] = 32'(i);
    end
    req_valid = 3'b111; res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (req_ready !== exp_rdy[c % 3]) begin
        bad++; $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, exp_rdy[c % 3]); end
      tick;
      total++; if (res_valid !== 1'b1 || res_id !== 2'(c % 3) || res_sum !== exp_sum[c % 3]) begin
        bad++; $display("FAIL fair_res[%0d]: got v=%b id=%0d sum=%0d want 1 %0d %0d",
                        c, res_valid, res_id, res_sum, c % 3, exp_sum[c % 3]); end
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_backpressure;
    // pointer is 0 here
    req_valid = 3'b001; res_ready = 1'b0;
    req_a[0*W +: W] = 32'd5; req_b[0*W +: W] = 32'd6;
    tick;
    req_valid = 3'b010;
    req_a[1*W +: W] = 32'd7; req_b[1*W +: W] = 32'd8;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 000", c, req_ready); end
      total++; if (res_valid !== 1'b1 || res_sum !== 32'd11 || res_id !== 2'd0) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b sum=%0d id=%0d want 1 11 0", c, res_valid, res_sum, res_id); end
      tick;
    end
    res_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL bp_release: got %b want 010", req_ready); end
    tick;
    req_valid = '0;
    #1;
    total++; if (res_valid !== 1'b1 || res_sum !== 32'd15 || res_id !== 2'd1) begin
      bad++; $display("FAIL bp_next: got v=%b sum=%0d id=%0d want 1 15 1", res_valid, res_sum, res_id); end
    tick;
  endtask

  task automatic test_reset_mid;
    // pointer is 2; only requester 1 asks, so pointer lands on 2 again
    req_valid = 3'b010; res_ready = 1'b0;
    req_a[1*W +: W] = 32'd1; req_b[1*W +: W] = 32'd2;
    tick;
    req_valid = 3'b101;
    req_a[0*W +: W] = 32'd40; req_b[0*W +: W] = 32'd2;
    req_a[2*W +: W] = 32'd50; req_b[2*W +: W] = 32'd3;
    total++; if (res_valid !== 1'b1 || res_id !== 2'd1) begin
      bad++; $display("FAIL mid_pre: got v=%b id=%0d want 1 1", res_valid, res_id); end
    reset = 1'b1;
    #1;
    total++; if (res_valid !== 1'b0 || res_sum !== 32'd0 || res_id !== 2'd0) begin
      bad++; $display("FAIL mid_async: got v=%b sum=%0d id=%0d want 0 0 0", res_valid, res_sum, res_id); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL mid_rst_ready: got %b want 000", req_ready); end
    @(negedge clk);
    reset = 1'b0; res_ready = 1'b1;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_first: got %b want 001", req_ready); end
    tick;
    total++; if (res_id !== 2'd0 || res_sum !== 32'd42) begin
      bad++; $display("FAIL mid_res0: got id=%0d sum=%0d want 0 42", res_id, res_sum); end
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL mid_second: got %b want 100", req_ready); end
    tick;
    total++; if (res_id !== 2'd2 || res_sum !== 32'd53) begin
      bad++; $display("FAIL mid_res2: got id=%0d sum=%0d want 2 53", res_id, res_sum); end
    req_valid = '0;
    tick;
  endtask

`ifdef SHARED_ADDER_ARB_STATS_EN
  task automatic test_stats;
    reset = 1'b1; #1; reset = 1'b0;
    req_valid = 3'b010; res_ready = 1'b1;
    for (int c = 0; c < 70000; c++) tick;
    req_valid = '0;
    tick;
    total++; if (stat_grants[16 +: 16] !== 16'hFFFF) begin
      bad++; $display("FAIL stat_sat: got %h want ffff", stat_grants[16 +: 16]); end
    total++; if (stat_grants[0 +: 16] !== 16'h0 || stat_grants[32 +: 16] !== 16'h0) begin
      bad++; $display("FAIL stat_other: got %h %h want 0 0", stat_grants[0 +: 16], stat_grants[32 +: 16]); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_fairness;
    test_backpressure;
    test_reset_mid;
`ifdef SHARED_ADDER_ARB_STATS_EN
    test_stats;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
